// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch stage.
package fetch_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } fetch_state_e;

  localparam int unsigned INST_BYTES   = 4;
  localparam int unsigned BRANCH_SHIFT = 2;

  // Clears the low address bits so a PC always points at a whole instruction word.
  function automatic logic [63:0] word_align(input logic [63:0] addr);
    return {addr[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory handshake, decode handshake and branch feedback.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 64
);
  logic [ADDR_W-1:0] IMemAddr;
  logic              IMemReq;
  logic              IMemValid;
  logic [31:0]       IMemData;
  logic [31:0]       Inst;
  logic              InstValid;
  logic              InstReady;
  logic [63:0]       BusImm;
  logic              Uncondbranch;
  logic              Branch;
  logic              ALUZero;
  logic [ADDR_W-1:0] PC;

  modport master (
    output IMemAddr, IMemReq, Inst, InstValid, PC,
    input  IMemValid, IMemData, InstReady, BusImm, Uncondbranch, Branch, ALUZero
  );

  modport slave (
    input  IMemAddr, IMemReq, Inst, InstValid, PC,
    output IMemValid, IMemData, InstReady, BusImm, Uncondbranch, Branch, ALUZero
  );
endinterface

// File: rtl/fetch_unit_next_pc.sv
// Combinational next-PC selection: sequential PC+4 or PC-relative branch target.
module next_pc_logic
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] PC,
  input  logic [63:0]       BusImm,
  input  logic              Uncondbranch,
  input  logic              Branch,
  input  logic              ALUZero,
  output logic [ADDR_W-1:0] NextPC
);

  logic              taken;
  logic [63:0]       imm_shifted;
  logic [ADDR_W-1:0] branch_off;
  logic [ADDR_W-1:0] seq_off;

  always_comb begin
    taken       = Uncondbranch | (Branch & ALUZero);
    imm_shifted = BusImm << BRANCH_SHIFT;
    // Signed cast keeps the offset sign-correct if ADDR_W ever exceeds 64.
    branch_off  = ADDR_W'($signed(imm_shifted));
    seq_off     = ADDR_W'(INST_BYTES);
    NextPC      = taken ? (PC + branch_off) : (PC + seq_off);
  end

endmodule

// File: rtl/fetch_unit.sv
// LEGv8 instruction-fetch stage: PC register, two-state fetch/issue FSM, next-PC update.
// Optional performance counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              Reset,
  fetch_unit_if.master      bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       InstCount,
  output logic [31:0]       TakenCount
`endif
);

  localparam logic [ADDR_W-1:0] PC_INIT = {RESET_PC[ADDR_W-1:2], 2'b00};

  fetch_state_e      state, state_next;
  logic [ADDR_W-1:0] pc, pc_next, next_pc;
  logic [31:0]       inst, inst_next;
  logic              req, req_next;
  logic              accept;

  next_pc_logic #(
    .ADDR_W (ADDR_W)
  ) u_next_pc (
    .PC           (pc),
    .BusImm       (bus.BusImm),
    .Uncondbranch (bus.Uncondbranch),
    .Branch       (bus.Branch),
    .ALUZero      (bus.ALUZero),
    .NextPC       (next_pc)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state <= FETCH;
      pc    <= PC_INIT;
      inst  <= '0;
      req   <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      inst  <= inst_next;
      req   <= req_next;
    end
  end

  // The request is registered so it first rises on the edge after reset release;
  // memory responses are only honoured while it is high.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    inst_next  = inst;
    req_next   = req;
    accept     = 1'b0;
    unique case (state)
      FETCH: begin
        req_next = 1'b1;
        if (req && bus.IMemValid) begin
          inst_next  = bus.IMemData;
          state_next = ISSUE;
          req_next   = 1'b0;
        end
      end
      ISSUE: begin
        req_next = 1'b0;
        if (bus.InstReady) begin
          accept     = 1'b1;
          pc_next    = next_pc;
          state_next = FETCH;
          req_next   = 1'b1;
        end
      end
    endcase
  end

  assign bus.IMemAddr  = pc;
  assign bus.PC        = pc;
  assign bus.IMemReq   = req;
  assign bus.Inst      = inst;
  assign bus.InstValid = (state == ISSUE);

`ifdef FETCH_PERF_CNT_EN
  logic taken;

  assign taken = bus.Uncondbranch | (bus.Branch & bus.ALUZero);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      InstCount  <= '0;
      TakenCount <= '0;
    end else if (accept) begin
      InstCount <= InstCount + 32'd1;
      if (taken) begin
        TakenCount <= TakenCount + 32'd1;
      end
    end
  end
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, branches, stall, wrap and async abort.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk   = 1'b0;
  logic Reset = 1'b1;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  logic [31:0] sb[$];

  fetch_unit_if #(.ADDR_W(64)) b0 ();
  fetch_unit_if #(.ADDR_W(64)) b1 ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] ic0, tc0, ic1, tc1;
`endif

  fetch_unit #(
    .ADDR_W   (64),
    .RESET_PC (64'h0)
  ) dut0 (
    .CLK   (clk),
    .Reset (Reset),
    .bus   (b0)
`ifdef FETCH_PERF_CNT_EN
    ,
    .InstCount  (ic0),
    .TakenCount (tc0)
`endif
  );

  fetch_unit #(
    .ADDR_W   (64),
    .RESET_PC (64'hFFFF_FFFF_FFFF_FFFC)
  ) dut1 (
    .CLK   (clk),
    .Reset (Reset),
    .bus   (b1)
`ifdef FETCH_PERF_CNT_EN
    ,
    .InstCount  (ic1),
    .TakenCount (tc1)
`endif
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memword(input logic [63:0] addr);
    return 32'hD280_0000 ^ (addr[31:0] * 32'h0101_0101);
  endfunction

  // One instruction: wait for the request, answer a cycle later, optionally stall,
  // then accept with the given branch inputs and check the resulting PC.
  task automatic do_fetch(input logic [63:0] pc, input logic [63:0] imm,
                          input logic ub, input logic br, input logic z,
                          input int unsigned stall, input logic [63:0] exp_next);
    int unsigned n = 0;
    logic [31:0] word, held;
    while (b0.IMemReq !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("imemreq_fetch", {63'd0, b0.IMemReq}, 64'd1);
    chk("imemaddr", b0.IMemAddr, pc);
    chk("instvalid_fetch", {63'd0, b0.InstValid}, 64'd0);
    // Branch inputs driven during FETCH must be ignored.
    b0.Uncondbranch = 1'b1;
    b0.BusImm       = 64'h40;
    @(negedge clk);
    b0.Uncondbranch = 1'b0;
    b0.BusImm       = '0;
    chk("pc_wait", b0.PC, pc);
    word = memword(pc);
    b0.IMemData  = word;
    b0.IMemValid = 1'b1;
    sb.push_back(word);
    @(negedge clk);
    b0.IMemValid = 1'b0;
    b0.IMemData  = $urandom;
    chk("instvalid_issue", {63'd0, b0.InstValid}, 64'd1);
    chk("imemreq_issue", {63'd0, b0.IMemReq}, 64'd0);
    held = sb.pop_front();
    chk("inst", {32'd0, b0.Inst}, {32'd0, held});
    for (int unsigned i = 0; i < stall; i++) begin
      b0.IMemValid = 1'b1;
      b0.IMemData  = ~held;
      @(negedge clk);
      chk("stall_valid", {63'd0, b0.InstValid}, 64'd1);
      chk("stall_inst", {32'd0, b0.Inst}, {32'd0, held});
      chk("stall_pc", b0.PC, pc);
      chk("stall_req", {63'd0, b0.IMemReq}, 64'd0);
    end
    b0.IMemValid    = 1'b0;
    b0.BusImm       = imm;
    b0.Uncondbranch = ub;
    b0.Branch       = br;
    b0.ALUZero      = z;
    b0.InstReady    = 1'b1;
    @(negedge clk);
    b0.InstReady    = 1'b0;
    b0.BusImm       = '0;
    b0.Uncondbranch = 1'b0;
    b0.Branch       = 1'b0;
    b0.ALUZero      = 1'b0;
    chk("next_pc", b0.PC, exp_next);
    chk("instvalid_after", {63'd0, b0.InstValid}, 64'd0);
  endtask

  initial begin
    {b0.IMemValid, b0.IMemData, b0.InstReady, b0.BusImm, b0.Uncondbranch, b0.Branch, b0.ALUZero} = '0;
    {b1.IMemValid, b1.IMemData, b1.InstReady, b1.BusImm, b1.Uncondbranch, b1.Branch, b1.ALUZero} = '0;

    repeat (3) @(negedge clk);
    chk("rst_pc", b0.PC, 64'h0);
    chk("rst_req", {63'd0, b0.IMemReq}, 64'd0);
    chk("rst_valid", {63'd0, b0.InstValid}, 64'd0);
    chk("rst_inst", {32'd0, b0.Inst}, 64'd0);
    chk("rst_pc_dut1", b1.PC, 64'hFFFF_FFFF_FFFF_FFFC);
    Reset = 1'b0;
    #1;
    chk("req_before_edge", {63'd0, b0.IMemReq}, 64'd0);
    @(negedge clk);

    do_fetch(64'h00, 64'h0, 1'b0, 1'b0, 1'b0, 0, 64'h04);
    do_fetch(64'h04, 64'h0, 1'b0, 1'b0, 1'b0, 0, 64'h08);
    do_fetch(64'h08, 64'h0, 1'b0, 1'b0, 1'b0, 0, 64'h0C);
    do_fetch(64'h0C, 64'h0, 1'b0, 1'b0, 1'b0, 0, 64'h10);
    do_fetch(64'h10, 64'h3, 1'b1, 1'b0, 1'b0, 0, 64'h1C);
    do_fetch(64'h1C, 64'h0, 1'b0, 1'b0, 1'b0, 0, 64'h20);
    do_fetch(64'h20, 64'h5, 1'b0, 1'b1, 1'b0, 0, 64'h24);
    do_fetch(64'h24, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b1, 0, 64'h1C);
    do_fetch(64'h1C, 64'h0, 1'b0, 1'b0, 1'b0, 3, 64'h20);

    // Wrap: dut1 has idled in FETCH without a response since reset release.
    chk("wrap_req", {63'd0, b1.IMemReq}, 64'd1);
    chk("wrap_addr", b1.IMemAddr, 64'hFFFF_FFFF_FFFF_FFFC);
    b1.IMemData  = 32'h1234_5678;
    b1.IMemValid = 1'b1;
    @(negedge clk);
    b1.IMemValid = 1'b0;
    chk("wrap_inst", {32'd0, b1.Inst}, 64'h1234_5678);
    b1.InstReady = 1'b1;
    @(negedge clk);
    b1.InstReady = 1'b0;
    chk("wrap_pc", b1.PC, 64'h0);

    // Abort mid-ISSUE on dut0 (currently at PC 0x20).
    chk("abort_pre_pc", b0.PC, 64'h20);
    @(negedge clk);
    b0.IMemData  = 32'hCAFE_F00D;
    b0.IMemValid = 1'b1;
    @(negedge clk);
    b0.IMemValid = 1'b0;
    chk("abort_pre_valid", {63'd0, b0.InstValid}, 64'd1);
    #2;
    Reset = 1'b1;
    #1;
    chk("abort_valid", {63'd0, b0.InstValid}, 64'd0);
    chk("abort_req", {63'd0, b0.IMemReq}, 64'd0);
    chk("abort_pc", b0.PC, 64'h0);
    chk("abort_inst", {32'd0, b0.Inst}, 64'd0);
    @(negedge clk);
    Reset = 1'b0;
    b0.IMemData  = 32'hDEAD_BEEF;
    b0.IMemValid = 1'b1;
    @(negedge clk);
    b0.IMemValid = 1'b0;
    chk("noreq_ignored_valid", {63'd0, b0.InstValid}, 64'd0);
    chk("noreq_ignored_req", {63'd0, b0.IMemReq}, 64'd1);

    // Five instructions, two taken branches.
    do_fetch(64'h00, 64'h2, 1'b1, 1'b0, 1'b0, 0, 64'h08);
    do_fetch(64'h08, 64'h0, 1'b0, 1'b0, 1'b0, 0, 64'h0C);
    do_fetch(64'h0C, 64'h1, 1'b0, 1'b1, 1'b1, 1, 64'h10);
    do_fetch(64'h10, 64'h7, 1'b0, 1'b1, 1'b0, 0, 64'h14);
    do_fetch(64'h14, 64'h0, 1'b0, 1'b0, 1'b0, 0, 64'h18);
`ifdef FETCH_PERF_CNT_EN
    chk("inst_count", {32'd0, ic0}, 64'd5);
    chk("taken_count", {32'd0, tc0}, 64'd2);
`endif
    Reset = 1'b1;
    #1;
    chk("final_rst_pc", b0.PC, 64'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("inst_count_rst", {32'd0, ic0}, 64'd0);
    chk("taken_count_rst", {32'd0, tc0}, 64'd0);
`endif
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
